// File: rtl/arch_map_table_pkg.sv
// Shared types and constants for the architectural map table and its restore walker.
package arch_map_table_pkg;

  localparam int AM_NUM_ARCH = 32;
  localparam int AM_NUM_PR   = 64;
  localparam int AM_ARCH_W   = $clog2(AM_NUM_ARCH);
  localparam int AM_PR_W     = $clog2(AM_NUM_PR);
  localparam int AM_ZERO_REG = 31;
  localparam int AM_ZERO_PR  = 31;

  typedef struct packed {
    logic [AM_ARCH_W-1:0] dest;
    logic [AM_PR_W-1:0]   T;
  } ARCH_MAP_RETIRE_IN_t;

  typedef struct packed {
    logic               valid;
    logic [AM_PR_W-1:0] Told;
  } ARCH_MAP_FL_OUT_t;

  // 'reg' is a keyword, so the logical index field is lreg.
  typedef struct packed {
    logic                 valid;
    logic [AM_ARCH_W-1:0] lreg;
    logic [AM_PR_W-1:0]   pr;
    logic                 done;
  } ARCH_MAP_RESTORE_OUT_t;

  typedef enum logic [1:0] {
    RST_IDLE = 2'd0,
    RST_WALK = 2'd1,
    RST_DONE = 2'd2
  } arch_map_restore_state_e;

endpackage

// File: rtl/arch_map_restore_walker.sv
// Restore FSM: replays the committed map one entry per cycle, or in one shot
// when ARCH_MAP_BULK_RESTORE_EN is defined. All restore outputs are registered.
module arch_map_restore_walker
  import arch_map_table_pkg::*;
#(
  parameter int NUM_ARCH = AM_NUM_ARCH,
  parameter int NUM_PR   = AM_NUM_PR
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  restore_req_i,
  input  logic [NUM_ARCH*$clog2(NUM_PR)-1:0]    table_d_i,
  output logic                                  retire_ready_o,
  output logic                                  restore_valid_o,
  output logic [$clog2(NUM_ARCH)-1:0]           restore_reg_o,
  output logic [$clog2(NUM_PR)-1:0]             restore_pr_o,
  output logic                                  restore_done_o
`ifdef ARCH_MAP_BULK_RESTORE_EN
  ,
  output logic [NUM_ARCH*$clog2(NUM_PR)-1:0]    restore_map_o
`endif
);

  localparam int ARCH_W = $clog2(NUM_ARCH);
  localparam int PR_W   = $clog2(NUM_PR);
  localparam logic [ARCH_W-1:0] LAST_IDX = ARCH_W'(NUM_ARCH - 1);

  arch_map_restore_state_e state_q, state_d;
  logic [ARCH_W-1:0]       idx_q, idx_d;
  ARCH_MAP_RESTORE_OUT_t   out_q, out_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RST_IDLE;
      idx_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RST_IDLE: begin
        if (restore_req_i) begin
`ifdef ARCH_MAP_BULK_RESTORE_EN
          state_d = RST_DONE;
`else
          state_d = RST_WALK;
          idx_d   = '0;
`endif
        end
      end
      RST_WALK: begin
        if (idx_q == LAST_IDX) state_d = RST_DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      RST_DONE: state_d = RST_IDLE;
      default:  state_d = RST_IDLE;
    endcase
  end

  // Outputs are computed from next state so the registered copies line up with the FSM.
  always_comb begin
    out_d = '0;
    case (state_d)
      RST_WALK: begin
        out_d.valid = 1'b1;
        out_d.lreg  = idx_d;
        out_d.pr    = table_d_i[int'(idx_d)*PR_W +: PR_W];
      end
      RST_DONE: begin
        out_d.done = 1'b1;
`ifdef ARCH_MAP_BULK_RESTORE_EN
        out_d.valid = 1'b1;
`endif
      end
      default: out_d = '0;
    endcase
  end

`ifdef ARCH_MAP_BULK_RESTORE_EN
  logic [NUM_ARCH*PR_W-1:0] map_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      map_q <= '0;
    end else if (state_q == RST_IDLE && restore_req_i) begin
      map_q <= table_d_i;
    end
  end

  assign restore_map_o = map_q;
`endif

  assign retire_ready_o  = (state_q == RST_IDLE);
  assign restore_valid_o = out_q.valid;
  assign restore_reg_o   = out_q.lreg;
  assign restore_pr_o    = out_q.pr;
  assign restore_done_o  = out_q.done;

endmodule

// File: rtl/arch_map_table.sv
// Committed logical->physical map: records retiring tags, releases Told one cycle later,
// and replays the map on recovery (ARCH_MAP_BULK_RESTORE_EN selects one-shot restore).
module arch_map_table
  import arch_map_table_pkg::*;
#(
  parameter int NUM_ARCH = AM_NUM_ARCH,
  parameter int NUM_PR   = AM_NUM_PR,
  parameter int ZERO_REG = AM_ZERO_REG,
  parameter int ZERO_PR  = AM_ZERO_PR
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                retire_en,
  output logic                                retire_ready,
  input  logic [$clog2(NUM_ARCH)-1:0]         retire_dest,
  input  logic [$clog2(NUM_PR)-1:0]           retire_T,
  output logic                                release_valid,
  output logic [$clog2(NUM_PR)-1:0]           release_Told,
  input  logic                                restore_req,
  output logic                                restore_valid,
  output logic [$clog2(NUM_ARCH)-1:0]         restore_reg,
  output logic [$clog2(NUM_PR)-1:0]           restore_pr,
  output logic                                restore_done
`ifdef ARCH_MAP_BULK_RESTORE_EN
  ,
  output logic [NUM_ARCH*$clog2(NUM_PR)-1:0]  restore_map
`endif
);

  localparam int ARCH_W = $clog2(NUM_ARCH);
  localparam int PR_W   = $clog2(NUM_PR);

  ARCH_MAP_RETIRE_IN_t               ret;
  ARCH_MAP_FL_OUT_t                  rel_q;
  logic [NUM_ARCH-1:0][PR_W-1:0]     table_q, table_d;
  logic                              fire, commit;

  assign ret    = '{dest: retire_dest, T: retire_T};
  assign fire   = retire_en && retire_ready;
  // Entries never hold ZERO_PR except ZERO_REG, so a released Told can never be ZERO_PR.
  assign commit = fire && (ret.dest != ARCH_W'(ZERO_REG)) && (ret.T != PR_W'(ZERO_PR));

  always_comb begin
    table_d = table_q;
    if (commit) table_d[ret.dest] = ret.T;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ARCH; i++) table_q[i] <= PR_W'(i);
    end else begin
      table_q <= table_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rel_q <= '0;
    end else begin
      rel_q.valid <= commit;
      if (commit) rel_q.Told <= table_q[ret.dest];
    end
  end

  assign release_valid = rel_q.valid;
  assign release_Told  = rel_q.Told;

  // The walker sees next-state table so a same-cycle retire is visible to the replay.
  arch_map_restore_walker #(
    .NUM_ARCH (NUM_ARCH),
    .NUM_PR   (NUM_PR)
  ) u_walker (
    .clock           (clock),
    .reset           (reset),
    .restore_req_i   (restore_req),
    .table_d_i       (table_d),
    .retire_ready_o  (retire_ready),
    .restore_valid_o (restore_valid),
    .restore_reg_o   (restore_reg),
    .restore_pr_o    (restore_pr),
    .restore_done_o  (restore_done)
`ifdef ARCH_MAP_BULK_RESTORE_EN
    ,
    .restore_map_o   (restore_map)
`endif
  );

endmodule

// File: tb/tb_arch_map_table.sv
// Directed bench for arch_map_table (sequential-walk build): retire/release, zero-reg, walk, reset abort.
module tb_arch_map_table;

  logic       clock;
  logic       reset;
  logic       retire_en;
  logic       retire_ready;
  logic [4:0] retire_dest;
  logic [5:0] retire_T;
  logic       release_valid;
  logic [5:0] release_Told;
  logic       restore_req;
  logic       restore_valid;
  logic [4:0] restore_reg;
  logic [5:0] restore_pr;
  logic       restore_done;
`ifdef ARCH_MAP_BULK_RESTORE_EN
  logic [32*6-1:0] restore_map;
`endif

  int n_chk;
  int n_err;
  logic [5:0] exp_map [32];

  arch_map_table dut (
    .clock         (clock),
    .reset         (reset),
    .retire_en     (retire_en),
    .retire_ready  (retire_ready),
    .retire_dest   (retire_dest),
    .retire_T      (retire_T),
    .release_valid (release_valid),
    .release_Told  (release_Told),
    .restore_req   (restore_req),
    .restore_valid (restore_valid),
    .restore_reg   (restore_reg),
    .restore_pr    (restore_pr),
    .restore_done  (restore_done)
`ifdef ARCH_MAP_BULK_RESTORE_EN
    ,
    .restore_map   (restore_map)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".ready"}, 64'(retire_ready), 64'd1);
    chk({tag, ".rel_v"}, 64'(release_valid), 64'd0);
    chk({tag, ".rel_t"}, 64'(release_Told), 64'd0);
    chk({tag, ".rst_v"}, 64'(restore_valid), 64'd0);
    chk({tag, ".rst_r"}, 64'(restore_reg), 64'd0);
    chk({tag, ".rst_p"}, 64'(restore_pr), 64'd0);
    chk({tag, ".done"}, 64'(restore_done), 64'd0);
  endtask

  // Expects restore_req already sampled; checks entries 1..31 then the done pulse.
  task automatic walk_rest(input string tag, input int req_at);
    for (int i = 1; i < 32; i++) begin
      if (i == req_at) restore_req = 1'b1;
      step();
      restore_req = 1'b0;
      chk({tag, ".v"}, 64'(restore_valid), 64'd1);
      chk({tag, ".reg"}, 64'(restore_reg), 64'(i));
      chk({tag, ".pr"}, 64'(restore_pr), 64'(exp_map[i]));
      chk({tag, ".rdy"}, 64'(retire_ready), 64'd0);
      chk({tag, ".rel"}, 64'(release_valid), 64'd0);
      chk({tag, ".dn"}, 64'(restore_done), 64'd0);
    end
    step();
    chk({tag, ".done"}, 64'(restore_done), 64'd1);
    chk({tag, ".done_v"}, 64'(restore_valid), 64'd0);
    chk({tag, ".done_rdy"}, 64'(retire_ready), 64'd0);
  endtask

  initial begin
    n_chk       = 0;
    n_err       = 0;
    reset       = 1'b0;
    retire_en   = 1'b0;
    retire_dest = '0;
    retire_T    = '0;
    restore_req = 1'b0;
    for (int i = 0; i < 32; i++) exp_map[i] = 6'(i);

    step();
    step();
    chk_reset_outs("rst");
    reset = 1'b1;
    step();

    // Retire 3->40, then 3->41 back-to-back, then a zero-reg retire.
    retire_en = 1'b1; retire_dest = 5'd3; retire_T = 6'd40;
    step();
    chk("r1.v", 64'(release_valid), 64'd1);
    chk("r1.told", 64'(release_Told), 64'd3);
    retire_dest = 5'd3; retire_T = 6'd41;
    step();
    chk("r2.v", 64'(release_valid), 64'd1);
    chk("r2.told", 64'(release_Told), 64'd40);
    exp_map[3] = 6'd41;
    retire_dest = 5'd31; retire_T = 6'd45;
    step();
    chk("rz.v", 64'(release_valid), 64'd0);
    retire_en = 1'b0;
    step();
    chk("idle.v", 64'(release_valid), 64'd0);

    // Restore with a same-cycle retire 5->50.
    retire_en = 1'b1; retire_dest = 5'd5; retire_T = 6'd50;
    restore_req = 1'b1;
    exp_map[5] = 6'd50;
    step();
    restore_req = 1'b0;
    chk("rr.rel_v", 64'(release_valid), 64'd1);
    chk("rr.told", 64'(release_Told), 64'd5);
    chk("w0.v", 64'(restore_valid), 64'd1);
    chk("w0.reg", 64'(restore_reg), 64'd0);
    chk("w0.pr", 64'(restore_pr), 64'(exp_map[0]));
    chk("w0.rdy", 64'(retire_ready), 64'd0);
    // Hold a retire pending through the walk; also re-request mid-walk.
    retire_dest = 5'd7; retire_T = 6'd60;
    walk_rest("w1", 10);
    step();
    chk("post.done", 64'(restore_done), 64'd0);
    chk("post.v", 64'(restore_valid), 64'd0);
    chk("post.rdy", 64'(retire_ready), 64'd1);
    chk("post.rel", 64'(release_valid), 64'd0);
    step();
    retire_en = 1'b0;
    chk("held.rel_v", 64'(release_valid), 64'd1);
    chk("held.told", 64'(release_Told), 64'd7);
    exp_map[7] = 6'd60;

    // Walk again and abort with reset at entry 10.
    restore_req = 1'b1;
    step();
    restore_req = 1'b0;
    for (int i = 1; i <= 10; i++) step();
    chk("ab.reg", 64'(restore_reg), 64'd10);
    chk("ab.pr", 64'(restore_pr), 64'(exp_map[10]));
    reset = 1'b0;
    #1;
    chk_reset_outs("abort");
    step();
    step();
    chk("abort.nodone", 64'(restore_done), 64'd0);
    chk("abort.nov", 64'(restore_valid), 64'd0);
    reset = 1'b1;
    step();
    chk("rel.rdy", 64'(retire_ready), 64'd1);

    // Table must be identity again.
    for (int i = 0; i < 32; i++) exp_map[i] = 6'(i);
    restore_req = 1'b1;
    step();
    restore_req = 1'b0;
    chk("w2.v0", 64'(restore_valid), 64'd1);
    chk("w2.pr0", 64'(restore_pr), 64'd0);
    walk_rest("w2", 0);
    step();
    chk("end.rdy", 64'(retire_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
